// File: rtl/final_project_seven_segment.sv
// Board top: fixed-sequence compute core (risc1) whose five 16-bit results are
// cycled in hex across a 4-digit common-anode seven-segment display.

module final_project_seven_segment_core (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem201,
    output logic [15:0] mem202,
    output logic [15:0] mem203,
    output logic [15:0] mem204,
    output logic [15:0] mem205
);
    localparam int unsigned STEP_W    = 7;
    localparam int unsigned FIB_STEPS = 20;
    localparam int unsigned SUM_LAST  = 100;
    localparam int unsigned FACT_LAST = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIB,
        ST_SUM,
        ST_FACT,
        ST_XOR,
        ST_ADD,
        ST_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step, step_nxt;
    logic [15:0]         fib_a, fib_a_nxt;
    logic [15:0]         fib_b, fib_b_nxt;
    logic [15:0]         acc, acc_nxt;
    logic [15:0]         prod, prod_nxt;
    logic [15:0]         mem201_nxt, mem202_nxt, mem203_nxt, mem204_nxt, mem205_nxt;

    // State and datapath registers; reset aborts any phase in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            step   <= '0;
            fib_a  <= '0;
            fib_b  <= 16'd1;
            acc    <= '0;
            prod   <= 16'd1;
            mem201 <= '0;
            mem202 <= '0;
            mem203 <= '0;
            mem204 <= '0;
            mem205 <= '0;
        end else begin
            state  <= state_nxt;
            step   <= step_nxt;
            fib_a  <= fib_a_nxt;
            fib_b  <= fib_b_nxt;
            acc    <= acc_nxt;
            prod   <= prod_nxt;
            mem201 <= mem201_nxt;
            mem202 <= mem202_nxt;
            mem203 <= mem203_nxt;
            mem204 <= mem204_nxt;
            mem205 <= mem205_nxt;
        end
    end

    // Next-state and datapath update; each result is written only at its phase end
    always_comb begin
        state_nxt  = state;
        step_nxt   = step;
        fib_a_nxt  = fib_a;
        fib_b_nxt  = fib_b;
        acc_nxt    = acc;
        prod_nxt   = prod;
        mem201_nxt = mem201;
        mem202_nxt = mem202;
        mem203_nxt = mem203;
        mem204_nxt = mem204;
        mem205_nxt = mem205;

        case (state)
            ST_IDLE: begin
                fib_a_nxt = '0;
                fib_b_nxt = 16'd1;
                step_nxt  = '0;
                state_nxt = ST_FIB;
            end
            ST_FIB: begin
                if (step == STEP_W'(FIB_STEPS)) begin
                    mem201_nxt = fib_a;
                    acc_nxt    = '0;
                    step_nxt   = STEP_W'(1);
                    state_nxt  = ST_SUM;
                end else begin
                    fib_a_nxt = fib_b;
                    fib_b_nxt = fib_a + fib_b;
                    step_nxt  = step + STEP_W'(1);
                end
            end
            ST_SUM: begin
                acc_nxt  = acc + 16'(step);
                step_nxt = step + STEP_W'(1);
                if (step == STEP_W'(SUM_LAST)) begin
                    mem202_nxt = acc + 16'(step);
                    prod_nxt   = 16'd1;
                    step_nxt   = STEP_W'(1);
                    state_nxt  = ST_FACT;
                end
            end
            ST_FACT: begin
                prod_nxt = prod * 16'(step);
                step_nxt = step + STEP_W'(1);
                if (step == STEP_W'(FACT_LAST)) begin
                    mem203_nxt = prod * 16'(step);
                    state_nxt  = ST_XOR;
                end
            end
            ST_XOR: begin
                mem204_nxt = mem201 ^ mem202;
                state_nxt  = ST_ADD;
            end
            ST_ADD: begin
                mem205_nxt = mem203 + mem202;
                state_nxt  = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule

module final_project_seven_segment #(
    parameter int unsigned REFRESH_BITS = 17,
    parameter int unsigned HOLD_BITS    = 28
) (
    input  logic       clk_i,
    input  logic       SW,
    output logic [3:0] disp_an_o,
    output logic [6:0] disp_seg_o
);
    logic [15:0]             mem201, mem202, mem203, mem204, mem205;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [HOLD_BITS-1:0]    hold_cnt;
    logic [2:0]              res_idx;
    logic [1:0]              digit_c;
    logic [15:0]             result_c;
    logic [3:0]              nibble_c;
    logic [3:0]              anode_c;
    logic [6:0]              seg_c;

    final_project_seven_segment_core risc1 (
        .clk    (clk_i),
        .rst_n  (SW),
        .mem201 (mem201),
        .mem202 (mem202),
        .mem203 (mem203),
        .mem204 (mem204),
        .mem205 (mem205)
    );

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h40;
            4'h1: hex_font = 7'h79;
            4'h2: hex_font = 7'h24;
            4'h3: hex_font = 7'h30;
            4'h4: hex_font = 7'h19;
            4'h5: hex_font = 7'h12;
            4'h6: hex_font = 7'h02;
            4'h7: hex_font = 7'h78;
            4'h8: hex_font = 7'h00;
            4'h9: hex_font = 7'h10;
            4'hA: hex_font = 7'h08;
            4'hB: hex_font = 7'h03;
            4'hC: hex_font = 7'h46;
            4'hD: hex_font = 7'h21;
            4'hE: hex_font = 7'h06;
            default: hex_font = 7'h0E;
        endcase
    endfunction

    // Digit selection from the scan counter and live result registers
    always_comb begin
        digit_c  = refresh_cnt[REFRESH_BITS-1 -: 2];
        result_c = '0;
        nibble_c = '0;
        case (res_idx)
            3'd0:    result_c = mem201;
            3'd1:    result_c = mem202;
            3'd2:    result_c = mem203;
            3'd3:    result_c = mem204;
            3'd4:    result_c = mem205;
            default: result_c = '0;
        endcase
        case (digit_c)
            2'd0:    nibble_c = result_c[3:0];
            2'd1:    nibble_c = result_c[7:4];
            2'd2:    nibble_c = result_c[11:8];
            default: nibble_c = result_c[15:12];
        endcase
        anode_c = ~(4'(1) << digit_c);
        seg_c   = hex_font(nibble_c);
    end

    // Scan/hold counters and registered display outputs
    always_ff @(posedge clk_i) begin
        if (!SW) begin
            refresh_cnt <= '0;
            hold_cnt    <= '0;
            res_idx     <= '0;
            disp_an_o   <= 4'hF;
            disp_seg_o  <= 7'h7F;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            hold_cnt    <= hold_cnt + HOLD_BITS'(1);
            if (hold_cnt == '1) begin
                res_idx <= (res_idx == 3'd4) ? 3'd0 : res_idx + 3'd1;
            end
            disp_an_o  <= anode_c;
            disp_seg_o <= seg_c;
        end
    end
endmodule

// File: tb/tb_final_project_seven_segment.sv
// Randomized scoreboard bench for the seven-segment result display and its
// fixed-sequence compute core.

module tb_final_project_seven_segment;
    localparam int RB = 4;
    localparam int HB = 8;

    logic       clk_i = 1'b0;
    logic       SW    = 1'b0;
    logic [3:0] disp_an_o;
    logic [6:0] disp_seg_o;

    final_project_seven_segment #(.REFRESH_BITS(RB), .HOLD_BITS(HB)) dut (
        .clk_i      (clk_i),
        .SW         (SW),
        .disp_an_o  (disp_an_o),
        .disp_seg_o (disp_seg_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         chk;
        logic [3:0] an;
        logic [6:0] seg;
        int         n;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          n_rel   = 0;
    logic [15:0] final_v[5];
    logic [6:0]  font[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic check_mems(input bit cleared);
        logic [15:0] e[5];
        for (int i = 0; i < 5; i++) e[i] = cleared ? 16'h0000 : final_v[i];
        check("mem201", dut.risc1.mem201, e[0]);
        check("mem202", dut.risc1.mem202, e[1]);
        check("mem203", dut.risc1.mem203, e[2]);
        check("mem204", dut.risc1.mem204, e[3]);
        check("mem205", dut.risc1.mem205, e[4]);
    endtask

    // Drive one clock of SW and predict the registered display after that edge
    task automatic step(input bit sw);
        exp_t        e;
        int          m, digit, idx;
        logic [15:0] v;
        logic [3:0]  nib;
        @(negedge clk_i);
        SW    = sw;
        e.chk = 1'b1;
        e.n   = n_rel;
        if (!sw) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            n_rel = 0;
        end else begin
            m     = n_rel;
            digit = (m % (1 << RB)) / (1 << (RB - 2));
            idx   = (m / (1 << HB)) % 5;
            v     = 16'h0000;
            if (m >= 150) v = final_v[idx];
            else if (m >= 20) e.chk = 1'b0;
            nib   = 4'((v >> (4 * digit)) & 16'hF);
            e.an  = 4'hF & ~(4'b0001 << digit);
            e.seg = font[nib];
            n_rel++;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: one registered display sample per clock
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    nm = $sformatf("display n=%0d", e.n);
                    check(nm, {5'b0, disp_an_o, disp_seg_o}, {5'b0, e.an, e.seg});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b, t, p;
        int          r;
        a = 16'h0000;
        b = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        p = 16'h0001;
        for (int k = 1; k <= 8; k++) p = 16'(p * 16'(k));
        final_v[0] = a;
        final_v[1] = 16'(100 * 101 / 2);
        final_v[2] = p;
        final_v[3] = final_v[0] ^ final_v[1];
        final_v[4] = final_v[2] + final_v[1];

        step(1'b0);
        step(1'b0);
        @(posedge clk_i);
        #2;
        check_mems(1'b1);

        repeat (60) step(1'b1);
        step(1'b0);
        @(posedge clk_i);
        #2;
        check_mems(1'b1);

        r = int'($urandom_range(30, 110));
        repeat (r) step(1'b1);
        r = int'($urandom_range(1, 3));
        repeat (r) step(1'b0);

        for (int i = 0; i < 1500; i++) begin
            step(1'b1);
            if (n_rel == 150) begin
                @(posedge clk_i);
                #2;
                check_mems(1'b0);
            end
        end

        @(posedge clk_i);
        #3;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
